hazard_forward_unit: RTL and testbench

Produces the 2-bit operand-select codes that drive the EX-stage 3:1 operand muxes. It also produces the load-use stall for the 5-stage RISC-V pipeline. It keeps its own shadow pipeline of destination-register and control bits for the EX, MEM and WB stages, fed from decode. It sits beside the ID/EX register and is the producer end of the select_i interface of the forwarding muxes.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/fwd_select.sv | 16 +
 rtl/hazard_forward_unit.sv | 60 ++++++
 tb/tb_hazard_forward_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared forwarding-select codes, register address width and shadow-pipeline stage entries.
package riscv_pkg;
    localparam int REG_ADDR_W = 5;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;
    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      regwrite;
        logic      memread;
        logic      valid;
    } ex_entry_t;
    typedef struct packed {
        reg_addr_t rd;
        logic      regwrite;
        logic      memread;
        logic      valid;
    } mem_entry_t;
    typedef struct packed {
        reg_addr_t rd;
        logic      regwrite;
        logic      valid;
    } wb_entry_t;
    // A live producer writing a non-x0 register that matches the consumer address.
    function automatic logic hits(input logic valid, input logic regwrite, input reg_addr_t rd, input reg_addr_t rs);
        return valid & regwrite & (rd != '0) & (rd == rs);
    endfunction
endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the EX operand source for one source register.
// Ports: rs (consumer address), mem / wb (shadow entries), sel (FWD_MEM over FWD_WB over FWD_RF).
module fwd_select
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  mem_entry_t            mem,
    input  wb_entry_t             wb,
    output fwd_sel_e              sel
);
    logic unused_mem_memread;
    assign unused_mem_memread = mem.memread;
    // MEM holds the younger producer, so it is checked first.
    assign sel = hits(mem.valid, mem.regwrite, mem.rd, rs) ? FWD_MEM :
                 hits(wb.valid, wb.regwrite, wb.rd, rs)    ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding selects and load-use stall for a 5-stage pipeline.
// Ports: clk_i, rst_ni (async active-low); id_* decode fields; hold_i freezes all shadow
// stages; flush_i squashes the instruction entering EX; forward_a_o / forward_b_o drive
// the EX operand muxes; stall_o is the load-use stall.
// Optional macro HAZARD_RF_BYPASS_EN adds id_bypass_a_o / id_bypass_b_o (WB-to-ID bypass).
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  id_valid_i,
    input  logic                  hold_i,
    input  logic                  flush_i,
`ifdef HAZARD_RF_BYPASS_EN
    output logic                  id_bypass_a_o,
    output logic                  id_bypass_b_o,
`endif
    output logic [1:0]            forward_a_o,
    output logic [1:0]            forward_b_o,
    output logic                  stall_o
);
    import riscv_pkg::*;
    ex_entry_t  ex_q, ex_d;
    mem_entry_t mem_q;
    wb_entry_t  wb_q;
    fwd_sel_e   sel_a, sel_b;
    // Flush and stall both turn the EX slot into a bubble.
    assign ex_d = (flush_i | stall_o) ? '0 :
                  '{rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i,
                    regwrite: id_regwrite_i & id_valid_i,
                    memread: id_memread_i & id_valid_i,
                    valid: id_valid_i};
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!hold_i) begin
            ex_q  <= ex_d;
            mem_q <= '{rd: ex_q.rd, regwrite: ex_q.regwrite, memread: ex_q.memread, valid: ex_q.valid};
            wb_q  <= '{rd: mem_q.rd, regwrite: mem_q.regwrite, valid: mem_q.valid};
        end
    end
    fwd_select u_fwd_a (.rs(ex_q.rs1), .mem(mem_q), .wb(wb_q), .sel(sel_a));
    fwd_select u_fwd_b (.rs(ex_q.rs2), .mem(mem_q), .wb(wb_q), .sel(sel_b));
    assign forward_a_o = ex_q.valid ? sel_a : FWD_RF;
    assign forward_b_o = ex_q.valid ? sel_b : FWD_RF;
    // A dependent instruction being discarded by flush must not stall.
    assign stall_o = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid_i &
                     ((ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i)) & ~flush_i;
`ifdef HAZARD_RF_BYPASS_EN
    assign id_bypass_a_o = hits(wb_q.valid, wb_q.regwrite, wb_q.rd, id_rs1_i);
    assign id_bypass_b_o = hits(wb_q.valid, wb_q.regwrite, wb_q.rd, id_rs2_i);
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed scoreboard bench for hazard_forward_unit.
module tb_hazard_forward_unit;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [4:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
    logic       id_regwrite_i = 1'b0, id_memread_i = 1'b0, id_valid_i = 1'b0;
    logic       hold_i = 1'b0, flush_i = 1'b0;
    logic [1:0] forward_a_o, forward_b_o;
    logic       stall_o;
`ifdef HAZARD_RF_BYPASS_EN
    logic       id_bypass_a_o, id_bypass_b_o;
`endif
    typedef struct {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        string      nm;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    hazard_forward_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .id_valid_i(id_valid_i),
        .hold_i(hold_i), .flush_i(flush_i),
`ifdef HAZARD_RF_BYPASS_EN
        .id_bypass_a_o(id_bypass_a_o), .id_bypass_b_o(id_bypass_b_o),
`endif
        .forward_a_o(forward_a_o), .forward_b_o(forward_b_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (forward_a_o !== e.fa || forward_b_o !== e.fb || stall_o !== e.st) begin
                errors++;
                $display("FAIL %s: got fa=%b fb=%b stall=%b, expected fa=%b fb=%b stall=%b",
                         e.nm, forward_a_o, forward_b_o, stall_o, e.fa, e.fb, e.st);
            end
        end
    end

    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic v, input logic h, input logic f,
                        input logic [1:0] fa, input logic [1:0] fb, input logic st, input string nm);
        exp_t e;
        @(posedge clk_i);
        #1;
        id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_regwrite_i = rw; id_memread_i = mr; id_valid_i = v;
        hold_i = h; flush_i = f;
        e.fa = fa; e.fb = fb; e.st = st; e.nm = nm;
        q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            step(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1,
                 1'($urandom), 1'($urandom), 2'b00, 2'b00, 1'b0, "rst_active");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "rst_idle");
        @(negedge clk_i); #2 rst_ni = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "post_rst");
        // back-to-back ALU
        step(1, 2, 5, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "alu_c1");
        step(5, 5, 6, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "alu_c2");
        step(5, 1, 7, 1, 0, 1, 0, 0, 2'b10, 2'b10, 1'b0, "alu_mem_fwd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1'b0, "alu_wb_fwd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "alu_drain1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "alu_drain2");
        // double producer: MEM wins
        step(1, 2, 3, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "dbl_d1");
        step(1, 1, 3, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "dbl_d2");
        step(3, 0, 7, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "dbl_d3");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1'b0, "dbl_mem_wins");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "dbl_drain1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "dbl_drain2");
        // x0 producer never forwards
        step(1, 2, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "x0_e1");
        step(0, 0, 8, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "x0_e2");
        step(0, 0, 9, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "x0_mem");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "x0_wb");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "x0_drain1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "x0_drain2");
        // load-use
        step(1, 0, 4, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1'b0, "lu_lw");
        step(4, 1, 8, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b1, "lu_stall");
        step(4, 1, 8, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "lu_bubble");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1'b0, "lu_fwd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "lu_drain1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "lu_drain2");
        // load to x0: no stall
        step(1, 0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1'b0, "lu0_lw");
        step(0, 1, 8, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "lu0_nostall");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "lu0_nofwd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "lu0_drain1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "lu0_drain2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "lu0_drain3");
        // flush masks stall
        step(1, 0, 4, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1'b0, "fl_lw");
        step(4, 1, 8, 1, 0, 1, 0, 1, 2'b00, 2'b00, 1'b0, "fl_masks_stall");
        step(4, 4, 10, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "fl_bubble");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1'b0, "fl_wb_fwd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "fl_drain");
        // flushed ALU producer never forwards
        step(1, 2, 11, 1, 0, 1, 0, 1, 2'b00, 2'b00, 1'b0, "fl_alu");
        step(11, 11, 12, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "fl_alu_bubble");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "fl_squashed_nofwd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "fl_drain2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "fl_drain3");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "fl_drain4");
        // hold during load-use stall
        step(2, 2, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "hd_add");
        step(1, 0, 4, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1'b0, "hd_lw");
        step(2, 4, 13, 1, 0, 1, 1, 0, 2'b10, 2'b00, 1'b1, "hd_hold1");
        step(2, 4, 13, 1, 0, 1, 1, 0, 2'b10, 2'b00, 1'b1, "hd_hold2");
        step(2, 4, 13, 1, 0, 1, 1, 0, 2'b10, 2'b00, 1'b1, "hd_hold3");
        step(2, 4, 13, 1, 0, 1, 0, 0, 2'b10, 2'b00, 1'b1, "hd_release");
        step(2, 4, 13, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "hd_bubble");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1'b0, "hd_one_bubble");
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "hd_drain");
        // reset mid-stall
        step(1, 0, 4, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1'b0, "rs_lw");
        step(4, 0, 14, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b1, "rs_stall");
        @(negedge clk_i); #2 rst_ni = 1'b0;
        step(4, 0, 14, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, "rs_in_reset");
        @(negedge clk_i); #2 rst_ni = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "rs_no_residual");
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
